// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, constants and control-word layout for pipe_ctrl
package pipe_ctrl_pkg;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_MEMWAIT = 2'd1;
   localparam logic [1:0] ST_HALT    = 2'd2;
   localparam logic [1:0] ST_STEP    = 2'd3;

   localparam int unsigned HALT_CODE = 10;
   localparam logic [4:0]  REG_ZERO  = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic fd_en;
      logic de_en;
      logic em_en;
      logic mw_en;
      logic fd_clr;
      logic de_clr;
      logic em_clr;
      logic mw_clr;
   } ctl_t;

   // FREEZE keeps mw_en high so the WB stage receives a bubble rather than replaying.
   localparam ctl_t CTL_ADV    = 9'b11111_0000;
   localparam ctl_t CTL_FREEZE = 9'b00001_0001;
   localparam ctl_t CTL_RESET  = 9'b00000_1111;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline status inputs and stage-register controls of pipe_ctrl
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       D_rs;
   logic [4:0]       D_rt;
   logic             D_use_rs;
   logic             D_use_rt;
   logic             D_jump;
   logic [4:0]       E_RW;
   logic             E_MemtoReg;
   logic             E_branch_taken;
   logic             M_MemtoReg;
   logic             M_MemWrite;
   logic             M_syscall;
   logic [31:0]      M_v0;
   logic             mem_ready;
   logic             go;
   logic             step_mode;
   logic             pc_en;
   logic             fd_en;
   logic             de_en;
   logic             em_en;
   logic             mw_en;
   logic             fd_clr;
   logic             de_clr;
   logic             em_clr;
   logic             mw_clr;
   logic             mem_req;
   logic             halted;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output D_rs, D_rt, D_use_rs, D_use_rt, D_jump, E_RW, E_MemtoReg, E_branch_taken,
             M_MemtoReg, M_MemWrite, M_syscall, M_v0, mem_ready, go, step_mode,
      input  pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr, mw_clr,
             mem_req, halted, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  D_rs, D_rt, D_use_rs, D_use_rt, D_jump, E_RW, E_MemtoReg, E_branch_taken,
             M_MemtoReg, M_MemWrite, M_syscall, M_v0, mem_ready, go, step_mode,
      output pc_en, fd_en, de_en, em_en, mw_en, fd_clr, de_clr, em_clr, mw_clr,
             mem_req, halted, mem_err, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use and branch/jump flush decode
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] d_rs_i,
   input  logic [4:0] d_rt_i,
   input  logic       d_use_rs_i,
   input  logic       d_use_rt_i,
   input  logic       d_jump_i,
   input  logic [4:0] e_rw_i,
   input  logic       e_memtoreg_i,
   input  logic       e_branch_taken_i,
   output logic       lu_o,
   output logic       fd_flush_o,
   output logic       de_flush_o
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = d_use_rs_i && (e_rw_i == d_rs_i);
   assign rt_hit = d_use_rt_i && (e_rw_i == d_rt_i);

   // A load into $zero never produces a value worth waiting for.
   assign lu_o       = e_memtoreg_i && (e_rw_i != REG_ZERO) && (rs_hit || rt_hit);
   assign fd_flush_o = e_branch_taken_i || d_jump_i;
   assign de_flush_o = e_branch_taken_i;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/halt sequencer for the 5-stage MIPS pipeline registers
module pipe_ctrl #(
   parameter int          CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned HALT_CODE   = pipe_ctrl_pkg::HALT_CODE
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);
   import pipe_ctrl_pkg::*;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic              go_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;

   ctl_t ctl;
   logic mem_acc;
   logic hlt;
   logic go_rise;
   logic lu;
   logic fd_flush;
   logic de_flush;
   logic flush_inc;
   logic stall_inc;

   pipe_hazard_detect u_hazard (
      .d_rs_i           (bus.D_rs),
      .d_rt_i           (bus.D_rt),
      .d_use_rs_i       (bus.D_use_rs),
      .d_use_rt_i       (bus.D_use_rt),
      .d_jump_i         (bus.D_jump),
      .e_rw_i           (bus.E_RW),
      .e_memtoreg_i     (bus.E_MemtoReg),
      .e_branch_taken_i (bus.E_branch_taken),
      .lu_o             (lu),
      .fd_flush_o       (fd_flush),
      .de_flush_o       (de_flush)
   );

   assign mem_acc = bus.M_MemtoReg || bus.M_MemWrite;
   assign hlt     = bus.M_syscall && (bus.M_v0 == 32'(HALT_CODE));
   assign go_rise = bus.go && !go_q;

   always_comb begin
      ctl       = CTL_ADV;
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      flush_inc = 1'b0;
      case (state_q)
         ST_RUN, ST_STEP: begin
            if (mem_acc && !bus.mem_ready) begin
               ctl     = CTL_FREEZE;
               state_d = ST_MEMWAIT;
               wait_d  = WAIT_W'(1);
            end else if (state_q == ST_RUN && hlt) begin
               ctl     = CTL_FREEZE;
               state_d = ST_HALT;
            end else begin
               if (fd_flush) begin
                  ctl.fd_clr = 1'b1;
                  ctl.de_clr = de_flush;
                  flush_inc  = 1'b1;
               end else if (lu) begin
                  ctl.pc_en  = 1'b0;
                  ctl.fd_en  = 1'b0;
                  ctl.de_clr = 1'b1;
               end
               if (state_q == ST_STEP) begin
                  state_d = bus.step_mode ? ST_HALT : ST_RUN;
               end
            end
         end
         ST_MEMWAIT: begin
            // A late mem_ready still wins over the timeout in the same cycle.
            if (bus.mem_ready) begin
               state_d = bus.step_mode ? ST_HALT : ST_RUN;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
               ctl       = CTL_FREEZE;
               mem_err_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               ctl    = CTL_FREEZE;
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            ctl = CTL_FREEZE;
            if (go_rise && !mem_err_q) begin
               state_d = ST_STEP;
            end
         end
      endcase
      if (rst) begin
         ctl = CTL_RESET;
      end
   end

   assign stall_inc = !ctl.pc_en && (state_q != ST_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         go_q        <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         go_q        <= bus.go;
         stall_cnt_q <= stall_cnt_q + (stall_inc ? CNT_W'(1) : CNT_W'(0));
         flush_cnt_q <= flush_cnt_q + (flush_inc ? CNT_W'(1) : CNT_W'(0));
      end
   end

   assign bus.pc_en     = ctl.pc_en;
   assign bus.fd_en     = ctl.fd_en;
   assign bus.de_en     = ctl.de_en;
   assign bus.em_en     = ctl.em_en;
   assign bus.mw_en     = ctl.mw_en;
   assign bus.fd_clr    = ctl.fd_clr;
   assign bus.de_clr    = ctl.de_clr;
   assign bus.em_clr    = ctl.em_clr;
   assign bus.mw_clr    = ctl.mw_clr;
   assign bus.mem_req   = mem_acc && (state_q != ST_HALT) && !rst;
   assign bus.halted    = (state_q == ST_HALT) && !rst;
   assign bus.mem_err   = mem_err_q;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule
